// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_wr_arbiter                                              |
// | Description : Round-robin arbiter sharing one FIFO write port between      |
// |               NUM_REQ stream requesters. The grant is held for a whole     |
// |               packet (PKT_LOCK=1) or for a bounded burst (PKT_LOCK=0).     |
// |               Data and flow control pass straight through; nothing is      |
// |               buffered here.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int PKT_LOCK  = 1,
    parameter int MAX_BURST = 4,
    parameter int IDW       = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_eop_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     fifo_non_full_i,
    output logic                     fifo_wr_o,
    output logic [WIDTH-1:0]         fifo_data_o,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [IDW-1:0]           grant_id_o,
    output logic                     busy_o,
    output logic [15:0]              beat_cnt_o
);

    // FSM encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    // Burst limit in the width of the burst counter
    localparam logic [7:0] c_MAX_BURST = 8'(MAX_BURST);

    // Requester that won last; its successor has the highest priority
    localparam logic [IDW-1:0] c_LAST_RST = IDW'(NUM_REQ - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [IDW-1:0]     r_last_id;
    logic [IDW-1:0]     r_grant_id;
    logic [NUM_REQ-1:0] r_grant;
    logic [7:0]         r_burst_cnt;
    logic [15:0]        r_beat_cnt;

    logic [NUM_REQ-1:0] w_mask_hi;
    logic [NUM_REQ-1:0] w_req_hi;
    logic               w_pick_found;
    logic [IDW-1:0]     w_pick_id;
    logic [NUM_REQ-1:0] w_pick_onehot;

    logic               w_busy;
    logic               w_sel_valid;
    logic               w_sel_eop;
    logic [WIDTH-1:0]   w_sel_data;
    logic               w_xfer;
    logic               w_release;
    logic [7:0]         w_burst_inc;

    assign w_busy = (r_state == c_ST_GRANT);

    // Round-robin pick: lowest valid index above last_id, else lowest valid index overall.
    always_comb begin
        w_mask_hi     = '0;
        w_pick_found  = 1'b0;
        w_pick_id     = '0;
        w_pick_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_mask_hi[k] = (IDW'(k) > r_last_id);
        end
        w_req_hi = req_valid_i & w_mask_hi;
        // Downward scans leave the smallest matching index; the upper region overrides.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                w_pick_found     = 1'b1;
                w_pick_id        = IDW'(k);
                w_pick_onehot    = '0;
                w_pick_onehot[k] = 1'b1;
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_hi[k]) begin
                w_pick_id        = IDW'(k);
                w_pick_onehot    = '0;
                w_pick_onehot[k] = 1'b1;
            end
        end
    end

    // Select the granted requester's valid/eop/data; an empty grant selects nothing.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_eop   = 1'b0;
        w_sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant[k]) begin
                w_sel_valid = req_valid_i[k];
                w_sel_eop   = req_eop_i[k];
                w_sel_data  = req_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Beat acceptance and grant release condition for the selected locking mode.
    always_comb begin
        w_burst_inc = r_burst_cnt + 8'd1;
        w_xfer      = w_busy & w_sel_valid & fifo_non_full_i;
        if (PKT_LOCK != 0) begin
            w_release = w_xfer & w_sel_eop;
        end else begin
            // A requester that stops presenting data gives up its burst early.
            w_release = (w_xfer && (w_burst_inc == c_MAX_BURST)) || !w_sel_valid;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: arbitrate in IDLE, hold in GRANT until release.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = c_ST_GRANT;
                end
            end
            c_ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Grant registers: load the pick on arbitration, clear and remember the owner on release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_last_id  <= c_LAST_RST;
        end else if ((r_state == c_ST_IDLE) && w_pick_found) begin
            r_grant    <= w_pick_onehot;
            r_grant_id <= w_pick_id;
        end else if ((r_state == c_ST_GRANT) && w_release) begin
            r_grant   <= '0;
            r_last_id <= r_grant_id;
        end
    end

    // Per-grant beat count, restarted at each new grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_burst_cnt <= '0;
        end else if ((r_state == c_ST_IDLE) && w_pick_found) begin
            r_burst_cnt <= '0;
        end else if (w_xfer) begin
            r_burst_cnt <= w_burst_inc;
        end
    end

    // Free-running count of all accepted beats, wrapping at 16 bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_beat_cnt <= '0;
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    assign req_ready_o = r_grant & {NUM_REQ{fifo_non_full_i}};
    assign fifo_wr_o   = w_xfer;
    assign fifo_data_o = w_sel_data;
    assign grant_o     = r_grant;
    assign grant_id_o  = r_grant_id;
    assign busy_o      = w_busy;
    assign beat_cnt_o  = r_beat_cnt;

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one `fifo` write port between `NUM_REQ` Avalon-ST-style requesters. It grants one requester at a time and holds the grant for a whole packet, or for a bounded burst when packet lock is disabled. Grant data is steered onto the FIFO `data_i`/`wr_i` pair, with flow control taken from the FIFO's `non_full_o`. It sits between the upstream stream sources and the shared `fifo` instance, in the same clock domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `WIDTH`, 32: data width; equals the connected `fifo` WIDTH.
- `PKT_LOCK`, 1: 1 = hold grant until an end-of-packet beat; 0 = hold grant for a burst.
- `MAX_BURST`, 4: maximum beats per grant when `PKT_LOCK`=0, range 1..255.
- `IDW`, `$clog2(NUM_REQ)`: width of the grant index (derived).
- `clk_i`  in  1  single clock; all logic is on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester valid.
- `req_data_i`  in  NUM_REQ*WIDTH  requester k occupies bits [k*WIDTH +: WIDTH].
- `req_eop_i`  in  NUM_REQ  end-of-packet marker, qualified by valid.
- `req_ready_o`  out  NUM_REQ  per-requester ready; at most one bit is high.
- `fifo_non_full_i`  in  1  from the FIFO `non_full_o`.
- `fifo_wr_o`  out  1  to the FIFO `wr_i`.
- `fifo_data_o`  out  WIDTH  to the FIFO `data_i`.
- `grant_o`  out  NUM_REQ  one-hot current grant; all zero in IDLE.
- `grant_id_o`  out  IDW  index of the current or most recent grant.
- `busy_o`  out  1  high in the GRANT state.
- `beat_cnt_o`  out  16  total accepted beats; wraps from 0xFFFF to 0.

## Operation
- **States:** IDLE and GRANT, held in a registered FSM.
- **IDLE:**
  - If any `req_valid_i` bit is high, pick the first set bit searching upward from `last_id+1`, wrapping modulo NUM_REQ.
  - Register the pick into `grant_o`/`grant_id_o`, clear `burst_cnt`, and go to GRANT.
  - If no bit is high, stay in IDLE.
- **GRANT, requester g:**
  - `req_ready_o[g]` = `fifo_non_full_i`; all other ready bits are 0.
  - A beat is accepted when `xfer` = `req_valid_i[g]` & `fifo_non_full_i`.
  - `fifo_wr_o` = `xfer` (combinational).
  - `fifo_data_o` = slice g of `req_data_i` in GRANT; it is 0 in IDLE.
  - On each `xfer`, `beat_cnt_o` increments by 1 (wrapping) and `burst_cnt` increments by 1.
- **Release (GRANT -> IDLE, `last_id` <= g), `PKT_LOCK`=1:**
  - Release on the `xfer` that carries `req_eop_i[g]`=1.
  - A deasserted `req_valid_i[g]` or `fifo_non_full_i` does not release; the grant waits.
- **Release, `PKT_LOCK`=0:**
  - Release on the `xfer` where `burst_cnt`+1 == MAX_BURST.
  - Also release on any GRANT cycle in which `req_valid_i[g]`=0.
  - `req_eop_i` is ignored.
- **Fairness:** after releasing requester g, g has the lowest priority in the next arbitration. When all requesters are continuously valid, the grant order is 0,1,…,NUM_REQ-1,0,…
- **Data passthrough:** the arbiter never buffers data. Backpressure is exactly the FIFO's `non_full_o`, including that signal's ready-latency gating.
- **Async reset:** `rst_i` high clears all state immediately, including mid-packet.
  - State = IDLE, `last_id` = NUM_REQ-1 (so requester 0 wins first), `grant_o`=0, `grant_id_o`=0.
  - `burst_cnt`=0, `beat_cnt_o`=0, `busy_o`=0, `req_ready_o`=0, `fifo_wr_o`=0, `fifo_data_o`=0.
  - A packet cut by reset is not resumed; the requester re-arbitrates from scratch.

## Timing
- **Arbitration latency:** a request seen high in IDLE at edge N gives `grant_o` and `busy_o` high after edge N; the first `xfer` can occur in the cycle after edge N.
- **Release bubble:** releasing at edge M puts the FSM in IDLE for the cycle after M. The earliest next grant is visible after edge M+1, so there is exactly one dead cycle between grants.
- **Ready timing:** `req_ready_o`, `fifo_wr_o` and `fifo_data_o` follow `fifo_non_full_i` and `req_valid_i` combinationally within the cycle, with no added register stage. The upstream sees the FIFO's ready behaviour unchanged.
- **Simultaneous release and request:** a request from the just-released requester in its release cycle is not considered until the IDLE cycle, and then only at lowest priority.
- **Counter update:** `beat_cnt_o` updates on the edge ending each `xfer` cycle.

## Test plan
- **Reset, then single packet:** with `PKT_LOCK`=1, assert `req_valid_i`=4'b0100 with 3 beats, eop on the 3rd, and `fifo_non_full_i`=1. Required: `grant_id_o`=2 one cycle later; `fifo_wr_o` high for 3 consecutive cycles with the matching data; `beat_cnt_o`=3; `busy_o` falls after the eop beat.
- **All four requesters valid, 2-beat packets:** required grant order 0,1,2,3,0 with one IDLE cycle between grants; the 8 beats land in the FIFO in that order.
- **Backpressure mid-packet:** drop `fifo_non_full_i` for 5 cycles during beat 2 of 4. Required: `fifo_wr_o`=0 and `req_ready_o`=0 for those cycles; the grant is held and the remaining beats complete once `fifo_non_full_i` returns.
- **`PKT_LOCK`=0, `MAX_BURST`=4:** requesters 0 and 1 are continuously valid. Required: grants alternate with 4 beats each; requester 0 dropping valid after 2 beats releases it after 2 beats.
- **Async reset mid-packet:** pulse `rst_i` between clock edges during beat 2. Required: all outputs go to their reset values immediately, without waiting for a clock edge; after release, requester 0 wins first.
- **Counter wrap:** preload traffic to 65535 beats, then send 2 more. Required: `beat_cnt_o` reads 0xFFFF, then 0x0000, then 0x0001.
